// File: rtl/instr_encoder_loader.sv
// ---------------------------------------------------------------------------
// instr_encoder_loader
//
// Packs decoded instruction fields back into 32-bit RISC-V instruction words.
// The block is the inverse of the immediate generator. It handles four
// formats: LD (I-type), SD (S-type), BRANCH (B-type) and R-type.
// Each bundle's immediate is range-checked. Good words are streamed, with
// incrementing byte addresses, to an instruction-memory write port.
// Bundles whose immediate does not fit are consumed and counted as errors.
//
// Parameters
//   BASE_ADDR  byte address of the first emitted word
//   MAX_WORDS  good words accepted before the block stops (>= 1)
//   CNT_W      counter width; must be able to hold MAX_WORDS
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   start             pulse that moves IDLE -> RUN
//   clear             synchronous restart to IDLE, overrides all other inputs
//   in_valid/in_ready field bundle handshake
//   in_fmt            0=I(LD) 1=S(SD) 2=B(BRANCH) 3=R
//   in_rd/rs1/rs2     register fields
//   in_funct3/funct7  function fields (funct7 used by R only)
//   in_imm            signed immediate (byte offset for B)
//   out_valid/ready   memory write handshake
//   out_word          encoded instruction
//   out_addr          BASE_ADDR + 4 * words written
//   count             words written (output handshakes)
//   err               sticky flag, set when any bundle has been rejected
//   err_cnt           rejected bundles, saturating at 255
//   done              FULL state reached and output register drained
// ---------------------------------------------------------------------------
module instr_encoder_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          MAX_WORDS = 256,
    parameter int          CNT_W     = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_fmt,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [2:0]       in_funct3,
    input  logic [6:0]       in_funct7,
    input  logic [31:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_word,
    output logic [31:0]      out_addr,
    output logic [CNT_W-1:0] count,
    output logic             err,
    output logic [7:0]       err_cnt,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FULL = 2'd2
    } state_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // Index of the last good word; accepting it fills the program.
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_WORDS - 1);

    state_t            state_q, state_d;
    logic              out_valid_q, out_valid_d;
    logic [31:0]       out_word_q, out_word_d;
    logic [31:0]       out_addr_q, out_addr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  acc_q, acc_d;
    logic              err_q, err_d;
    logic [7:0]        err_cnt_q, err_cnt_d;

    logic [31:0]       enc_word;
    logic              imm_ok;
    logic              fits_12;
    logic              fits_13;
    logic              xfer;
    logic              out_hs;

    // A 12-bit signed immediate fits when bits 31..11 are all sign copies.
    // A B-type offset needs bits 31..12 as sign copies and must be even,
    // because bit 0 is not encoded.
    assign fits_12 = (&in_imm[31:11]) | ~(|in_imm[31:11]);
    assign fits_13 = ((&in_imm[31:12]) | ~(|in_imm[31:12])) & ~in_imm[0];

    // Field packing; the opcode is implied by the format selector.
    always_comb begin
        enc_word = '0;
        imm_ok   = 1'b1;
        case (in_fmt)
            2'd0: begin
                enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, OPC_LOAD};
                imm_ok   = fits_12;
            end
            2'd1: begin
                enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3,
                            in_imm[4:0], OPC_STORE};
                imm_ok   = fits_12;
            end
            2'd2: begin
                enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                            in_imm[4:1], in_imm[11], OPC_BRANCH};
                imm_ok   = fits_13;
            end
            default: begin
                enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, OPC_OP};
                imm_ok   = 1'b1;
            end
        endcase
    end

    // The output register may reload in the same cycle it drains,
    // which keeps throughput at one word per cycle.
    assign in_ready = (state_q == ST_RUN) && (!out_valid_q || out_ready);
    assign xfer     = in_valid && in_ready;
    assign out_hs   = out_valid_q && out_ready;

    // Next-state logic. Clear is applied last so that it wins over
    // everything else on the same edge, and any pending word is discarded.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_word_d  = out_word_q;
        out_addr_d  = out_addr_q;
        count_d     = count_q;
        acc_d       = acc_q;
        err_d       = err_q;
        err_cnt_d   = err_cnt_q;

        if (out_hs) begin
            out_valid_d = 1'b0;
            count_d     = count_q + CNT_W'(1);
            out_addr_d  = out_addr_q + 32'd4;
        end

        if (xfer) begin
            if (imm_ok) begin
                out_valid_d = 1'b1;
                out_word_d  = enc_word;
                acc_d       = acc_q + CNT_W'(1);
                if (acc_q == LAST_IDX) begin
                    state_d = ST_FULL;
                end
            end else begin
                err_d = 1'b1;
                if (err_cnt_q != 8'hFF) begin
                    err_cnt_d = err_cnt_q + 8'd1;
                end
            end
        end

        if ((state_q == ST_IDLE) && start) begin
            state_d = ST_RUN;
        end

        if (clear) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            out_word_d  = '0;
            out_addr_d  = BASE_ADDR;
            count_d     = '0;
            acc_d       = '0;
            err_d       = 1'b0;
            err_cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            out_word_q  <= '0;
            out_addr_q  <= BASE_ADDR;
            count_q     <= '0;
            acc_q       <= '0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_word_q  <= out_word_d;
            out_addr_q  <= out_addr_d;
            count_q     <= count_d;
            acc_q       <= acc_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_word  = out_word_q;
    assign out_addr  = out_addr_q;
    assign count     = count_q;
    assign err       = err_q;
    assign err_cnt   = err_cnt_q;
    assign done      = (state_q == ST_FULL) && !out_valid_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// ---------------------------------------------------------------------------
// tb_instr_encoder_loader
//
// Directed testbench for instr_encoder_loader, built with MAX_WORDS=4.
// Inputs are driven and outputs are sampled on the falling clock edge.
// The DUT registers on the rising edge.
// ---------------------------------------------------------------------------
module tb_instr_encoder_loader;

    localparam int CNT_W = 9;

    logic             clk;
    logic             rst;
    logic             start;
    logic             clear;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_fmt;
    logic [4:0]       in_rd;
    logic [4:0]       in_rs1;
    logic [4:0]       in_rs2;
    logic [2:0]       in_funct3;
    logic [6:0]       in_funct7;
    logic [31:0]      in_imm;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_word;
    logic [31:0]      out_addr;
    logic [CNT_W-1:0] count;
    logic             err;
    logic [7:0]       err_cnt;
    logic             done;

    int checks;
    int failures;

    instr_encoder_loader #(
        .BASE_ADDR (32'h0),
        .MAX_WORDS (4),
        .CNT_W     (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fmt    (in_fmt),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_funct7 (in_funct7),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_addr  (out_addr),
        .count     (count),
        .err       (err),
        .err_cnt   (err_cnt),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one field bundle with in_valid high. It does not wait.
    task automatic drive_bundle(input logic [1:0] fmt, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [2:0] f3, input logic [6:0] f7,
                                input logic [31:0] imm);
        in_fmt    = fmt;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_funct3 = f3;
        in_funct7 = f7;
        in_imm    = imm;
        in_valid  = 1'b1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL rst_in_ready got=%b exp=0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_word !== 32'h0) begin failures++; $display("[TB] FAIL rst_out_word got=%h exp=0", out_word); end
        checks++; if (out_addr !== 32'h0) begin failures++; $display("[TB] FAIL rst_out_addr got=%h exp=0", out_addr); end
        checks++; if (count !== 9'd0) begin failures++; $display("[TB] FAIL rst_count got=%0d exp=0", count); end
        checks++; if (err !== 1'b0 || err_cnt !== 8'd0) begin failures++; $display("[TB] FAIL rst_err got=%b/%0d exp=0/0", err, err_cnt); end
        checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL rst_done got=%b exp=0", done); end
    endtask

    // Encodes I, S and B words back to back with the sink always ready.
    task automatic test_encode();
        out_ready = 1'b1;
        pulse_start();
        drive_bundle(2'd0, 5'd5, 5'd2, 5'd0, 3'd3, 7'd0, 32'd8);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL enc_in_ready got=%b exp=1", in_ready); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_word !== 32'h00813283 || out_addr !== 32'h0)
            begin failures++; $display("[TB] FAIL enc_i got=%b/%h/%h exp=1/00813283/00000000", out_valid, out_word, out_addr); end
        drive_bundle(2'd1, 5'd0, 5'd2, 5'd6, 3'd3, 7'd0, -32'sd4);
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_word !== 32'hFE613E23 || out_addr !== 32'h4)
            begin failures++; $display("[TB] FAIL enc_s got=%b/%h/%h exp=1/fe613e23/00000004", out_valid, out_word, out_addr); end
        drive_bundle(2'd2, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -32'sd8);
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_word !== 32'hFE208CE3 || out_addr !== 32'h8)
            begin failures++; $display("[TB] FAIL enc_b got=%b/%h/%h exp=1/fe208ce3/00000008", out_valid, out_word, out_addr); end
        checks++; if (count !== 9'd2) begin failures++; $display("[TB] FAIL enc_count_mid got=%0d exp=2", count); end
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (count !== 9'd3 || out_valid !== 1'b0 || out_addr !== 32'hC)
            begin failures++; $display("[TB] FAIL enc_drain got=%0d/%b/%h exp=3/0/0000000c", count, out_valid, out_addr); end
    endtask

    // Out-of-range immediates plus the in-range boundary values.
    task automatic test_range();
        pulse_clear();
        checks++; if (count !== 9'd0 || out_addr !== 32'h0) begin failures++; $display("[TB] FAIL rng_clear got=%0d/%h exp=0/0", count, out_addr); end
        pulse_start();
        drive_bundle(2'd0, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'd2048);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || err !== 1'b1 || err_cnt !== 8'd1)
            begin failures++; $display("[TB] FAIL rng_i_bad got=%b/%b/%0d exp=0/1/1", out_valid, err, err_cnt); end
        drive_bundle(2'd2, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || err_cnt !== 8'd2 || count !== 9'd0)
            begin failures++; $display("[TB] FAIL rng_b_odd got=%b/%0d/%0d exp=0/2/0", out_valid, err_cnt, count); end
        drive_bundle(2'd3, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 32'hDEADBEEF);
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_word !== 32'h403100B3 || out_addr !== 32'h0)
            begin failures++; $display("[TB] FAIL rng_r got=%b/%h/%h exp=1/403100b3/00000000", out_valid, out_word, out_addr); end
        drive_bundle(2'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd2048);
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_word !== 32'h80000003 || out_addr !== 32'h4)
            begin failures++; $display("[TB] FAIL rng_i_min got=%b/%h/%h exp=1/80000003/00000004", out_valid, out_word, out_addr); end
        drive_bundle(2'd2, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4094);
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_word !== 32'h7E000FE3 || out_addr !== 32'h8)
            begin failures++; $display("[TB] FAIL rng_b_max got=%b/%h/%h exp=1/7e000fe3/00000008", out_valid, out_word, out_addr); end
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (count !== 9'd3 || err !== 1'b1 || err_cnt !== 8'd2)
            begin failures++; $display("[TB] FAIL rng_end got=%0d/%b/%0d exp=3/1/2", count, err, err_cnt); end
    endtask

    // Backpressure holds the word, then back-to-back drain resumes.
    task automatic test_back_to_back();
        pulse_clear();
        pulse_start();
        out_ready = 1'b0;
        drive_bundle(2'd0, 5'd5, 5'd2, 5'd0, 3'd3, 7'd0, 32'd8);
        @(negedge clk);
        drive_bundle(2'd1, 5'd0, 5'd2, 5'd6, 3'd3, 7'd0, -32'sd4);
        for (int i = 0; i < 5; i++) begin
            checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_word !== 32'h00813283 || out_addr !== 32'h0)
                begin failures++; $display("[TB] FAIL bp_hold[%0d] got=%b/%b/%h/%h exp=0/1/00813283/00000000", i, in_ready, out_valid, out_word, out_addr); end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (count !== 9'd1 || out_word !== 32'hFE613E23 || out_addr !== 32'h4)
            begin failures++; $display("[TB] FAIL bp_release got=%0d/%h/%h exp=1/fe613e23/00000004", count, out_word, out_addr); end
        drive_bundle(2'd2, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -32'sd8);
        @(negedge clk);
        checks++; if (count !== 9'd2 || out_valid !== 1'b1 || out_word !== 32'hFE208CE3 || out_addr !== 32'h8)
            begin failures++; $display("[TB] FAIL bp_b2b got=%0d/%b/%h/%h exp=2/1/fe208ce3/00000008", count, out_valid, out_word, out_addr); end
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (count !== 9'd3 || out_valid !== 1'b0) begin failures++; $display("[TB] FAIL bp_drain got=%0d/%b exp=3/0", count, out_valid); end
    endtask

    // Six bundles offered with MAX_WORDS=4: only four are written.
    task automatic test_full();
        logic [31:0] exp_word [4];
        exp_word[0] = 32'h00008083;
        exp_word[1] = 32'h00108103;
        exp_word[2] = 32'h00208183;
        exp_word[3] = 32'h00308203;
        pulse_clear();
        pulse_start();
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k >= 1 && k <= 4) begin
                checks++; if (out_valid !== 1'b1 || out_word !== exp_word[k-1] || out_addr !== 32'(4 * (k - 1)))
                    begin failures++; $display("[TB] FAIL full_word[%0d] got=%b/%h/%h exp=1/%h/%h", k-1, out_valid, out_word, out_addr, exp_word[k-1], 32'(4 * (k - 1))); end
            end
            drive_bundle(2'd0, 5'(k + 1), 5'd1, 5'd0, 3'd0, 7'd0, 32'(k));
            checks++; if (in_ready !== (k < 4)) begin failures++; $display("[TB] FAIL full_in_ready[%0d] got=%b exp=%b", k, in_ready, (k < 4)); end
            if (k == 4) begin
                checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL full_done_early got=%b exp=0", done); end
            end
            if (k == 5) begin
                checks++; if (done !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("[TB] FAIL full_done got=%b/%b exp=1/0", done, out_valid); end
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++; if (count !== 9'd4 || done !== 1'b1 || out_addr !== 32'h10)
            begin failures++; $display("[TB] FAIL full_end got=%0d/%b/%h exp=4/1/00000010", count, done, out_addr); end
        pulse_clear();
        checks++; if (count !== 9'd0 || out_addr !== 32'h0 || done !== 1'b0 || in_ready !== 1'b0)
            begin failures++; $display("[TB] FAIL full_clear got=%0d/%h/%b/%b exp=0/0/0/0", count, out_addr, done, in_ready); end
    endtask

    // Asynchronous reset while a word is pending, followed by a restart.
    task automatic test_async_reset();
        pulse_start();
        out_ready = 1'b0;
        drive_bundle(2'd0, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'd2048);
        @(negedge clk);
        drive_bundle(2'd0, 5'd5, 5'd2, 5'd0, 3'd3, 7'd0, 32'd8);
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || err !== 1'b1) begin failures++; $display("[TB] FAIL ar_pre got=%b/%b exp=1/1", out_valid, err); end
        #2 rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || out_word !== 32'h0 || out_addr !== 32'h0 || count !== 9'd0 ||
                      err !== 1'b0 || err_cnt !== 8'd0 || in_ready !== 1'b0 || done !== 1'b0)
            begin failures++; $display("[TB] FAIL ar_reset got=%b/%h/%h/%0d/%b/%0d/%b/%b exp=0/0/0/0/0/0/0/0", out_valid, out_word, out_addr, count, err, err_cnt, in_ready, done); end
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        pulse_start();
        drive_bundle(2'd0, 5'd5, 5'd2, 5'd0, 3'd3, 7'd0, 32'd8);
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_word !== 32'h00813283 || out_addr !== 32'h0)
            begin failures++; $display("[TB] FAIL ar_restart got=%b/%h/%h exp=1/00813283/00000000", out_valid, out_word, out_addr); end
        @(negedge clk);
        checks++; if (count !== 9'd1 || out_addr !== 32'h4) begin failures++; $display("[TB] FAIL ar_count got=%0d/%h exp=1/00000004", count, out_addr); end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        start     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_fmt    = 2'd0;
        in_rd     = 5'd0;
        in_rs1    = 5'd0;
        in_rs2    = 5'd0;
        in_funct3 = 3'd0;
        in_funct7 = 7'd0;
        in_imm    = 32'd0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_encode();
        test_range();
        test_back_to_back();
        test_full();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
